axi4_burst_mem: RTL and testbench
=================================

# axi4_burst_mem

Parametrised single-port AXI4 slave memory. It is the burst-capable, width- and depth-configurable successor to the fixed 32-bit, single-beat block-memory wrappers used for weight and state storage in the LSTM accelerator. It terminates one AXI4 slave port with independent read and write engines on an internal dual-port array. It supports FIXED/INCR/WRAP bursts up to 256 beats, narrow transfers, byte strobes and out-of-range error responses.

## Interface
- DATA_W, 32: data width in bits; 32 or 64.
- ADDR_W, 14: byte-address width.
- DEPTH, 1024: number of DATA_W-wide words.
- ID_W, 4: AXI ID width.

Ports (one clock; reset is asynchronous and active-low):
- sys_clock  in  1  sole clock, rising edge.
- reset_rtl  in  1  asynchronous, active-low reset.
- awid/awaddr/awlen/awsize/awburst  in  ID_W/ADDR_W/8/3/2  write address.
- awvalid in 1; awready out 1.
- wdata/wstrb/wlast/wvalid  in  DATA_W/DATA_W/8/1/1  write data.
- wready out 1.
- bid/bresp/bvalid  out  ID_W/2/1  write response; bready in 1.
- arid/araddr/arlen/arsize/arburst  in  ID_W/ADDR_W/8/3/2  read address.
- arvalid in 1; arready out 1.
- rid/rdata/rresp/rlast/rvalid  out  ID_W/DATA_W/2/1/1  read data; rready in 1.

## Operation
- Word index = addr >> log2(DATA_W/8).
- Beat address advance depends on burst type:
  - FIXED: address constant.
  - INCR: address += 1<<size.
  - WRAP: address wraps at a boundary aligned to (len+1)<<size.
- Error conditions, each giving SLVERR (2'b10):
  - size > log2(DATA_W/8): whole burst.
  - WRAP with len not in {1,3,7,15}: whole burst.
  - Word index >= DEPTH: that beat only.
- Errored write beats are not written. Errored read beats return rdata 0.
- bresp is sticky: one errored beat makes the whole write response SLVERR.
- Write FSM: W_IDLE -> (AW handshake) W_DATA -> (beat count == awlen) W_RESP -> (bready) W_IDLE.
  - Each accepted W beat is written at the handshake edge, honouring wstrb.
  - The beat counter ends the burst. A wlast value that disagrees with the counter sets bresp SLVERR but does not change the beat count.
- Read FSM: R_IDLE -> (AR handshake) R_BURST -> (last beat accepted) R_IDLE.
  - A 2-entry output skid buffer keeps rdata/rresp/rlast/rid stable while rvalid && !rready.
- Read and write engines run concurrently. On a same-word read/write collision in the same cycle, the read returns the old data (read-first).
- Memory contents are not reset.

## Timing
- Reset values: awready 0, arready 0, wready 0, bvalid 0, rvalid 0, rlast 0, bresp 0, rresp 0, bid 0, rid 0, rdata 0.
- awready/arready rise on the first sys_clock edge after reset_rtl deasserts. They are high only in the IDLE states.
- wready is high from the cycle after the AW handshake until the final beat is accepted.
- bvalid asserts the cycle after the final W beat. It holds until bready; awready returns the following cycle.
- Read latency: first rvalid 2 cycles after the AR handshake.
- Throughput is one beat per cycle with rready held high, and no beat is lost or duplicated under any rready pattern. rlast is high on the final beat only.
- Write throughput is one beat per cycle.
- Reset asserted mid-burst: all state clears asynchronously and the in-flight burst is discarded. Beats already written remain in memory.

## Configuration
- AXI4_BURST_MEM_WRAP_EN:
  - Defined: WRAP bursts are supported as above.
  - Undefined: the WRAP address path is removed and any awburst/arburst of 2'b10 completes its full beat count with SLVERR. No memory writes occur and reads return 0.

## Structure
- Package axi4_burst_mem_pkg holds:
  - burst encodings (FIXED 2'b00, INCR 2'b01, WRAP 2'b10);
  - response constants (OKAY 2'b00, SLVERR 2'b10);
  - write/read FSM state enums.
- Sub-module axi4_burst_addr_gen computes the next beat address from (addr, len, size, burst) and flags errors. It is instantiated once per engine.

## Test plan
- Single write 0x100=0xDEADBEEF, wstrb 0xF, then single read 0x100 -> bresp OKAY; rdata 0xDEADBEEF, rresp OKAY, rlast 1.
- INCR len 3 write at 0x200 of 1,2,3,4; INCR len 3 read with rready toggling every other cycle -> 1,2,3,4 in order, rlast on beat 4 only.
- WRAP len 3 write at 0x108 of A,B,C,D; INCR read of 0x100 len 3 -> C,D,A,B. With the macro undefined -> bresp SLVERR and memory unchanged.
- Write 0xFFFFFFFF to 0x40, then 0x12345678 with wstrb 0x5 -> read 0xFF34FF78.
- Write to 0x1000 (word index 1024) -> bresp SLVERR, word 0 unchanged; read of 0x1000 -> rdata 0, rresp SLVERR.
- reset_rtl low during beat 2 of an INCR len 7 write -> bvalid 0, wready 0 immediately. After release, beats 0-1 read back written, and a new single write completes OKAY.

Source files
------------

// File: rtl/axi4_burst_mem_pkg.sv
// Shared encodings for the AXI4 burst memory: burst types, response codes and engine states.
package axi4_burst_mem_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [0:0] {
    R_IDLE  = 1'b0,
    R_BURST = 1'b1
  } r_state_e;

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Next-beat address and error flags for one burst engine.
// WRAP support is compiled in only when AXI4_BURST_MEM_WRAP_EN is defined.
module axi4_burst_addr_gen
  import axi4_burst_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        len_i,
  input  logic [2:0]        size_i,
  input  logic [1:0]        burst_i,
  output logic [ADDR_W-1:0] next_addr_o,
  output logic [IDX_W-1:0]  word_idx_o,
  output logic              burst_err_o,
  output logic              oob_o
);

  localparam int         BYTE_SH  = $clog2(DATA_W / 8);
  localparam logic [2:0] MAX_SIZE = 3'(BYTE_SH);

  logic [ADDR_W-1:0] word_full;
  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] inc_addr;

  assign word_full  = addr_i >> BYTE_SH;
  assign word_idx_o = word_full[IDX_W-1:0];
  assign oob_o      = 32'(word_full) >= 32'(DEPTH);
  assign incr       = ADDR_W'(1) << size_i;
  assign inc_addr   = addr_i + incr;

`ifdef AXI4_BURST_MEM_WRAP_EN
  // Wrap window is (len+1)<<size bytes, aligned to its own size.
  logic [ADDR_W-1:0] wrap_mask;
  logic              wrap_len_ok;
  assign wrap_mask   = ((ADDR_W'(len_i) + ADDR_W'(1)) << size_i) - ADDR_W'(1);
  assign wrap_len_ok = (len_i == 8'd1) || (len_i == 8'd3) || (len_i == 8'd7) || (len_i == 8'd15);
`else
  logic unused_len;
  assign unused_len = ^len_i;
`endif

  always_comb begin
    next_addr_o = addr_i;
    burst_err_o = (size_i > MAX_SIZE);
    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_INCR:  next_addr_o = inc_addr;
`ifdef AXI4_BURST_MEM_WRAP_EN
      BURST_WRAP: begin
        next_addr_o = (addr_i & ~wrap_mask) | (inc_addr & wrap_mask);
        if (!wrap_len_ok) burst_err_o = 1'b1;
      end
`else
      BURST_WRAP:  burst_err_o = 1'b1;
`endif
      default:     burst_err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/axi4_burst_mem.sv
// AXI4 slave memory with independent burst read/write engines over one dual-port array.
// Define AXI4_BURST_MEM_WRAP_EN to enable WRAP bursts; otherwise they complete with SLVERR.
module axi4_burst_mem
  import axi4_burst_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 1024,
  parameter int ID_W   = 4
) (
  input  logic                sys_clock,
  input  logic                reset_rtl,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready,
  output w_state_e            w_state_o,
  output r_state_e            r_state_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int E_W    = ID_W + DATA_W + 3;

  // Handshake rule on every channel: a beat transfers on the rising edge where
  // valid and ready are both high; ready/valid outputs here are registered.

  logic [DATA_W-1:0] mem [DEPTH];

  // ---------------- write engine ----------------
  w_state_e          w_state_q, w_state_d;
  logic              awready_q, wready_q, bvalid_q;
  logic [ID_W-1:0]   bid_q;
  logic [1:0]        bresp_q;
  logic [ADDR_W-1:0] w_addr_q, w_next;
  logic [7:0]        w_len_q, w_cnt_q;
  logic [2:0]        w_size_q;
  logic [1:0]        w_burst_q;
  logic              w_err_q;
  logic [IDX_W-1:0]  w_idx;
  logic              w_burst_err, w_oob;
  logic              aw_hs, w_hs, w_last_beat, w_beat_err, w_last_bad;

  axi4_burst_addr_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_wgen (
    .addr_i(w_addr_q), .len_i(w_len_q), .size_i(w_size_q), .burst_i(w_burst_q),
    .next_addr_o(w_next), .word_idx_o(w_idx), .burst_err_o(w_burst_err), .oob_o(w_oob)
  );

  assign aw_hs       = awvalid && awready_q;
  assign w_hs        = wvalid && wready_q;
  assign w_last_beat = (w_cnt_q == w_len_q);
  assign w_beat_err  = w_burst_err || w_oob;
  assign w_last_bad  = (wlast != w_last_beat);

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_hs) w_state_d = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_state_d = W_RESP;
      W_RESP:  if (bvalid_q && bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge sys_clock or negedge reset_rtl) begin
    if (!reset_rtl) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= (w_state_d == W_IDLE);
      wready_q  <= (w_state_d == W_DATA);
      bvalid_q  <= (w_state_d == W_RESP);
      if (aw_hs) begin
        bid_q     <= awid;
        w_addr_q  <= awaddr;
        w_len_q   <= awlen;
        w_size_q  <= awsize;
        w_burst_q <= awburst;
        w_cnt_q   <= '0;
        w_err_q   <= 1'b0;
      end
      if (w_hs) begin
        w_addr_q <= w_next;
        w_cnt_q  <= w_cnt_q + 8'd1;
        w_err_q  <= w_err_q | w_beat_err | w_last_bad;
        if (w_last_beat)
          bresp_q <= (w_err_q || w_beat_err || w_last_bad) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // Array is deliberately outside the reset domain so it can map to block RAM.
  always_ff @(posedge sys_clock) begin
    if (w_hs && !w_beat_err) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign awready   = awready_q;
  assign wready    = wready_q;
  assign bvalid    = bvalid_q;
  assign bid       = bid_q;
  assign bresp     = bresp_q;
  assign w_state_o = w_state_q;

  // ---------------- read engine ----------------
  r_state_e          r_state_q, r_state_d;
  logic              arready_q;
  logic [ID_W-1:0]   arid_q;
  logic [ADDR_W-1:0] r_addr_q, r_next;
  logic [7:0]        r_len_q, r_cnt_q;
  logic [2:0]        r_size_q;
  logic [1:0]        r_burst_q;
  logic              r_all_q;
  logic [IDX_W-1:0]  r_idx;
  logic              r_burst_err, r_oob;
  logic              ar_hs, r_pop, r_issue;
  logic [2:0]        r_occ;
  logic              p_valid_q, p_last_q, p_err_q;
  logic [DATA_W-1:0] p_data_q;
  logic [E_W-1:0]    r_beat, r_s0_q, r_s0_d, r_s1_q, r_s1_d;
  logic [1:0]        r_fcnt_q, r_fcnt_d;

  axi4_burst_addr_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_rgen (
    .addr_i(r_addr_q), .len_i(r_len_q), .size_i(r_size_q), .burst_i(r_burst_q),
    .next_addr_o(r_next), .word_idx_o(r_idx), .burst_err_o(r_burst_err), .oob_o(r_oob)
  );

  assign ar_hs  = arvalid && arready_q;
  assign rvalid = (r_fcnt_q != 2'd0);
  assign r_pop  = rvalid && rready;
  // Issue only if the beat, one cycle in the pipe, will still find a free skid slot.
  assign r_occ   = {1'b0, r_fcnt_q} + {2'b00, p_valid_q} - {2'b00, r_pop};
  assign r_issue = (r_state_q == R_BURST) && !r_all_q && (r_occ <= 3'd1);
  assign r_beat  = {arid_q, (p_err_q ? {DATA_W{1'b0}} : p_data_q),
                    (p_err_q ? RESP_SLVERR : RESP_OKAY), p_last_q};

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_BURST;
      R_BURST: if (r_pop && rlast) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    r_s0_d   = r_s0_q;
    r_s1_d   = r_s1_q;
    r_fcnt_d = r_fcnt_q;
    case ({p_valid_q, r_pop})
      2'b01: begin
        r_s0_d   = r_s1_q;
        r_fcnt_d = r_fcnt_q - 2'd1;
      end
      2'b10: begin
        if (r_fcnt_q == 2'd0) r_s0_d = r_beat;
        else                  r_s1_d = r_beat;
        r_fcnt_d = r_fcnt_q + 2'd1;
      end
      2'b11: begin
        if (r_fcnt_q == 2'd1) begin
          r_s0_d = r_beat;
        end else begin
          r_s0_d = r_s1_q;
          r_s1_d = r_beat;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clock or negedge reset_rtl) begin
    if (!reset_rtl) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      arid_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_all_q   <= 1'b0;
      p_valid_q <= 1'b0;
      p_last_q  <= 1'b0;
      p_err_q   <= 1'b0;
      r_s0_q    <= '0;
      r_s1_q    <= '0;
      r_fcnt_q  <= '0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= (r_state_d == R_IDLE);
      p_valid_q <= r_issue;
      r_s0_q    <= r_s0_d;
      r_s1_q    <= r_s1_d;
      r_fcnt_q  <= r_fcnt_d;
      if (ar_hs) begin
        arid_q    <= arid;
        r_addr_q  <= araddr;
        r_len_q   <= arlen;
        r_size_q  <= arsize;
        r_burst_q <= arburst;
        r_cnt_q   <= '0;
        r_all_q   <= 1'b0;
      end
      if (r_issue) begin
        r_addr_q <= r_next;
        r_cnt_q  <= r_cnt_q + 8'd1;
        p_last_q <= (r_cnt_q == r_len_q);
        p_err_q  <= r_burst_err || r_oob;
        if (r_cnt_q == r_len_q) r_all_q <= 1'b1;
      end
    end
  end

  // Same-edge write to this word is not yet visible here: read-first.
  always_ff @(posedge sys_clock) begin
    if (r_issue) p_data_q <= mem[r_idx];
  end

  assign {rid, rdata, rresp, rlast} = r_s0_q;
  assign arready   = arready_q;
  assign r_state_o = r_state_q;

endmodule

// File: tb/tb_axi4_burst_mem.sv
// Directed self-checking bench for axi4_burst_mem; WRAP expectations follow AXI4_BURST_MEM_WRAP_EN.
module tb_axi4_burst_mem;
  import axi4_burst_mem_pkg::*;

  logic        sys_clock = 1'b0;
  logic        reset_rtl;
  logic [3:0]  awid, arid, bid, rid;
  logic [13:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  w_state_e    w_state_dbg;
  r_state_e    r_state_dbg;

  int total = 0;
  int bad   = 0;

  logic [31:0] wbuf [16];
  logic [3:0]  sbuf [16];
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [3:0]  rd_id;
  int          rd_n, rd_first, rd_span;
  logic [1:0]  b_resp;
  logic [3:0]  b_id;
  logic [31:0] exp_w [4];
  logic [1:0]  exp_wresp;

  axi4_burst_mem dut (
    .sys_clock(sys_clock), .reset_rtl(reset_rtl),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .w_state_o(w_state_dbg), .r_state_o(r_state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 sys_clock = ~sys_clock;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish before 500us");
    $fatal(1, "watchdog");
  end

  // ---------------- check / driver tasks ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clock);
    #1;
  endtask

  task automatic aw_send(input logic [13:0] a, input logic [7:0] len, input logic [1:0] burst,
                         input logic [2:0] size, input logic [3:0] id);
    int t = 0;
    awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    while (!awready && t < 50) begin step(); t++; end
    chk("awready_wait", awready, 1);
    step();
    awvalid = 1'b0;
    chk("wready_after_aw", wready, 1);
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s, input logic last);
    int t = 0;
    wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
    while (!wready && t < 50) begin step(); t++; end
    chk("wready_wait", wready, 1);
    step();
    wvalid = 1'b0;
  endtask

  task automatic b_recv();
    int t = 0;
    bready = 1'b1;
    while (!bvalid && t < 50) begin step(); t++; end
    chk("bvalid_wait", bvalid, 1);
    b_resp = bresp;
    b_id   = bid;
    step();
    bready = 1'b0;
    chk("bvalid_drop", bvalid, 0);
    chk("awready_after_b", awready, 1);
  endtask

  task automatic write_burst(input logic [13:0] a, input logic [7:0] len, input logic [1:0] burst,
                             input logic [2:0] size, input logic [3:0] id);
    aw_send(a, len, burst, size, id);
    for (int i = 0; i <= int'(len); i++) w_send(wbuf[i], sbuf[i], i == int'(len));
    chk("bvalid_after_last_w", bvalid, 1);
    chk("wready_after_last_w", wready, 0);
    b_recv();
  endtask

  task automatic write1(input logic [13:0] a, input logic [31:0] d, input logic [3:0] s);
    wbuf[0] = d;
    sbuf[0] = s;
    write_burst(a, 8'd0, BURST_INCR, 3'd2, 4'd1);
  endtask

  task automatic read_burst(input logic [13:0] a, input logic [7:0] len, input logic [1:0] burst,
                            input logic toggle, input logic [3:0] id);
    int t = 0;
    int c = 0;
    arid = id; araddr = a; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
    while (!arready && t < 50) begin step(); t++; end
    chk("arready_wait", arready, 1);
    step();
    arvalid = 1'b0;
    rd_n = 0;
    rd_first = -1;
    while (rd_n <= int'(len) && c < 200) begin
      rready = toggle ? c[0] : 1'b1;
      if (rvalid && rd_first < 0) rd_first = c;
      if (rvalid && rready) begin
        rd_data[rd_n] = rdata;
        rd_resp[rd_n] = rresp;
        rd_last[rd_n] = rlast;
        rd_id = rid;
        rd_n++;
      end
      step();
      c++;
    end
    rready = 1'b0;
    rd_span = c - rd_first;
    chk("read_beats", rd_n, int'(len) + 1);
    chk("rvalid_after_burst", rvalid, 0);
    chk("arready_after_burst", arready, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset_rtl = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b0;
    repeat (3) step();

    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_bid", bid, 0);
    chk("rst_rid", rid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_wstate", w_state_dbg, W_IDLE);
    reset_rtl = 1'b1;
    chk("awready_before_edge", awready, 0);
    step();
    chk("awready_first_edge", awready, 1);
    chk("arready_first_edge", arready, 1);

    // single write/read
    write1(14'h100, 32'hDEADBEEF, 4'hF);
    chk("single_bresp", b_resp, RESP_OKAY);
    chk("single_bid", b_id, 4'd1);
    read_burst(14'h100, 8'd0, BURST_INCR, 1'b0, 4'd5);
    chk("single_rdata", rd_data[0], 32'hDEADBEEF);
    chk("single_rresp", rd_resp[0], RESP_OKAY);
    chk("single_rlast", rd_last[0], 1);
    chk("single_rid", rd_id, 4'd5);
    chk("read_latency", rd_first, 2);

    // INCR len 3 with toggling and steady rready
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
    write_burst(14'h200, 8'd3, BURST_INCR, 3'd2, 4'd2);
    chk("incr_bresp", b_resp, RESP_OKAY);
    read_burst(14'h200, 8'd3, BURST_INCR, 1'b1, 4'd6);
    for (int i = 0; i < 4; i++) begin
      chk("incr_tog_data", rd_data[i], 32'(i + 1));
      chk("incr_tog_last", rd_last[i], (i == 3));
      chk("incr_tog_resp", rd_resp[i], RESP_OKAY);
    end
    read_burst(14'h200, 8'd3, BURST_INCR, 1'b0, 4'd6);
    chk("incr_full_rate_span", rd_span, 4);
    chk("incr_full_rate_b3", rd_data[3], 32'd4);

    // WRAP len 3 at 0x108 over prefilled 0x100..0x10C
    wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
    write_burst(14'h100, 8'd3, BURST_INCR, 3'd2, 4'd3);
    wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC; wbuf[3] = 32'hD;
    write_burst(14'h108, 8'd3, BURST_WRAP, 3'd2, 4'd3);
`ifdef AXI4_BURST_MEM_WRAP_EN
    exp_wresp = RESP_OKAY;
    exp_w[0] = 32'hC; exp_w[1] = 32'hD; exp_w[2] = 32'hA; exp_w[3] = 32'hB;
`else
    exp_wresp = RESP_SLVERR;
    exp_w[0] = 32'h11; exp_w[1] = 32'h22; exp_w[2] = 32'h33; exp_w[3] = 32'h44;
`endif
    chk("wrap_bresp", b_resp, exp_wresp);
    read_burst(14'h100, 8'd3, BURST_INCR, 1'b0, 4'd3);
    for (int i = 0; i < 4; i++) chk("wrap_readback", rd_data[i], exp_w[i]);

    // byte strobes
    write1(14'h040, 32'hFFFFFFFF, 4'hF);
    write1(14'h040, 32'h12345678, 4'h5);
    read_burst(14'h040, 8'd0, BURST_INCR, 1'b0, 4'd0);
    chk("strobe_rdata", rd_data[0], 32'hFF34FF78);

    // out-of-range word index
    write1(14'h000, 32'hCAFEF00D, 4'hF);
    write1(14'h1000, 32'h55555555, 4'hF);
    chk("oob_bresp", b_resp, RESP_SLVERR);
    read_burst(14'h000, 8'd0, BURST_INCR, 1'b0, 4'd0);
    chk("oob_word0_kept", rd_data[0], 32'hCAFEF00D);
    read_burst(14'h1000, 8'd0, BURST_INCR, 1'b0, 4'd7);
    chk("oob_rdata", rd_data[0], 32'h0);
    chk("oob_rresp", rd_resp[0], RESP_SLVERR);
    write1(14'h0FFC, 32'h0BADCAFE, 4'hF);
    chk("last_word_bresp", b_resp, RESP_OKAY);
    read_burst(14'h0FFC, 8'd1, BURST_INCR, 1'b0, 4'd7);
    chk("edge_b0_data", rd_data[0], 32'h0BADCAFE);
    chk("edge_b0_resp", rd_resp[0], RESP_OKAY);
    chk("edge_b1_data", rd_data[1], 32'h0);
    chk("edge_b1_resp", rd_resp[1], RESP_SLVERR);

    // oversize transfer: whole burst errored, nothing written
    write1(14'h080, 32'h00000077, 4'hF);
    wbuf[0] = 32'h99999999; sbuf[0] = 4'hF;
    write_burst(14'h080, 8'd0, BURST_INCR, 3'd3, 4'd4);
    chk("size_err_bresp", b_resp, RESP_SLVERR);
    read_burst(14'h080, 8'd0, BURST_INCR, 1'b0, 4'd0);
    chk("size_err_mem_kept", rd_data[0], 32'h77);

    // wlast disagreeing with the beat count
    aw_send(14'h090, 8'd1, BURST_INCR, 3'd2, 4'd9);
    w_send(32'h1111, 4'hF, 1'b1);
    chk("early_wlast_still_open", wready, 1);
    w_send(32'h2222, 4'hF, 1'b0);
    chk("late_wlast_bvalid", bvalid, 1);
    b_recv();
    chk("wlast_bresp", b_resp, RESP_SLVERR);
    chk("wlast_bid", b_id, 4'd9);
    read_burst(14'h090, 8'd1, BURST_INCR, 1'b0, 4'd0);
    chk("wlast_b0", rd_data[0], 32'h1111);
    chk("wlast_b1", rd_data[1], 32'h2222);

    // FIXED burst keeps hitting one word
    wbuf[0] = 32'h5; wbuf[1] = 32'h6; wbuf[2] = 32'h7;
    sbuf[0] = 4'hF;  sbuf[1] = 4'hF;  sbuf[2] = 4'hF;
    write_burst(14'h060, 8'd2, BURST_FIXED, 3'd2, 4'd0);
    read_burst(14'h064, 8'd0, BURST_INCR, 1'b1, 4'd0);
    chk("fixed_neighbour", rd_data[0] === 32'h6, 0);
    read_burst(14'h060, 8'd2, BURST_FIXED, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) chk("fixed_rdata", rd_data[i], 32'h7);

    // reset during beat 2 of an INCR len 7 write
    for (int i = 0; i < 8; i++) sbuf[i] = 4'hF;
    aw_send(14'h300, 8'd7, BURST_INCR, 3'd2, 4'd2);
    w_send(32'hA0, 4'hF, 1'b0);
    w_send(32'hA1, 4'hF, 1'b0);
    wdata = 32'hA2; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
    #2;
    reset_rtl = 1'b0;
    #1;
    chk("midrst_wready", wready, 0);
    chk("midrst_bvalid", bvalid, 0);
    chk("midrst_wstate", w_state_dbg, W_IDLE);
    wvalid = 1'b0;
    step();
    reset_rtl = 1'b1;
    step();
    chk("midrst_awready_back", awready, 1);
    read_burst(14'h300, 8'd2, BURST_INCR, 1'b0, 4'd0);
    chk("midrst_b0", rd_data[0], 32'hA0);
    chk("midrst_b1", rd_data[1], 32'hA1);
    chk("midrst_b2_unwritten", rd_data[2] === 32'hA2, 0);
    write1(14'h310, 32'h600DF00D, 4'hF);
    chk("postrst_bresp", b_resp, RESP_OKAY);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
